keypad_scan_ctrl: RTL and testbench

Keypad scan controller for the 4x4 matrix keypad that feeds player direction and menu commands into the game logic. It drives the column lines one at a time, waits a programmable settle time, samples the row lines through a synchronizer, and debounces across full scans. Each debounced key press is delivered as a single key-code event over a valid/ready handshake to the game controller.

---
 rtl/keypad_scan_ctrl.sv | 106 ++++++++++
 tb/tb_keypad_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with per-scan debounce and valid/ready key events; define KEYPAD_REPEAT_EN for auto-repeat
module keypad_scan_ctrl #(
  parameter int SETTLE_CYC     = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun,
  input  logic       ovr_clr
);
  localparam int SW = $clog2(SETTLE_CYC);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [63:0] MAP = {4'd13, 4'd12, 4'd11, 4'd10, 4'd15, 4'd9, 4'd6, 4'd3,
                                 4'd0, 4'd8, 4'd5, 4'd2, 4'd14, 4'd7, 4'd4, 4'd1};
  logic [3:0] rs1, rs2, act, acc_code, res_code, prev_code, held_code, evt_code;
  logic [SW-1:0] cnt;
  logic [1:0] col, hits, tot, r;
  logic [2:0] cur_n, sum;
  logic [DW-1:0] deb, deb_n;
  logic sample, scan_end, res_key, prev_key, same, stable, press, rel, rep_evt, evt;
  assign cols     = ~(4'b0001 << col);
  assign act      = ~rs2;
  assign sample   = cnt == SW'(SETTLE_CYC - 1);
  assign scan_end = sample && col == 2'd3;
  assign cur_n    = {2'b0, act[0]} + {2'b0, act[1]} + {2'b0, act[2]} + {2'b0, act[3]};
  assign sum      = {1'b0, hits} + cur_n;
  assign tot      = sum > 3'd1 ? 2'd2 : sum[1:0];
  assign r        = act[0] ? 2'd0 : act[1] ? 2'd1 : act[2] ? 2'd2 : 2'd3;
  assign res_code = cur_n != 3'd0 ? MAP[{col, r, 2'b00} +: 4] : acc_code;
  assign res_key  = tot == 2'd1;
  assign same     = res_key == prev_key && (!res_key || res_code == prev_code);
  assign deb_n    = !same ? DW'(1) : deb == DW'(DEBOUNCE_SCANS) ? deb : deb + DW'(1);
  assign stable   = scan_end && deb_n == DW'(DEBOUNCE_SCANS);
  assign press    = stable && res_key && (!key_held || held_code != res_code);
  assign rel      = stable && !res_key && key_held;
  assign evt      = press || rep_evt;
  assign evt_code = press ? res_code : held_code;
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep;
  assign rep_evt = scan_end && key_held && !press && !rel && rep == RW'(REPEAT_SCANS - 1);
  // full scans since the press or the last repeat while a key stays held
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rep <= '0;
    else if (scan_end) rep <= (!key_held || press || rel || rep_evt) ? '0 : rep + RW'(1);
`else
  assign rep_evt = 1'b0;
`endif
  // two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rs2, rs1} <= 8'hff;
    else {rs2, rs1} <= {rs1, rows};
  // settle counter and one-cold column sequencer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      col <= '0;
    end else begin
      cnt <= sample ? '0 : cnt + SW'(1);
      col <= sample ? col + 2'd1 : col;
    end
  // hit count (saturating at 2) and code gathered over columns 0-2 of the scan
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hits     <= '0;
      acc_code <= '0;
    end else if (sample) begin
      hits     <= scan_end ? 2'd0 : tot;
      acc_code <= scan_end ? 4'd0 : res_code;
    end
  // previous scan result, debounce count and held key, updated once per scan
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_key  <= 1'b0;
      prev_code <= '0;
      deb       <= '0;
      key_held  <= 1'b0;
      held_code <= '0;
    end else if (scan_end) begin
      prev_key  <= res_key;
      prev_code <= res_code;
      deb       <= deb_n;
      key_held  <= press | (key_held & ~rel);
      if (press) held_code <= res_code;
    end
  // single-entry event register; an event that finds it full and stalled is dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (evt && (!key_valid || key_ready)) begin
        key_valid <= 1'b1;
        key_code  <= evt_code;
      end else if (key_ready) key_valid <= 1'b0;
      overrun <= (evt && key_valid && !key_ready) || (overrun && !ovr_clr);
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: randomized scan-level checks of keypad_scan_ctrl against a behavioural keypad model
module tb_keypad_scan_ctrl;
  localparam int S = 4, D = 3, R = 4;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, key_ready = 1'b0, ovr_clr = 1'b0;
  logic [3:0] rows, cols, key_code;
  logic key_valid, key_held, overrun;
  logic [15:0] mask = '0;
  int checks = 0, failures = 0;
  int code_tab [16] = '{1, 4, 7, 14, 2, 5, 8, 0, 3, 6, 9, 15, 10, 11, 12, 13};
  bit m_held, m_valid, m_ovr;
  int m_hcode, m_code, m_rep;
  int hist[$], exp_q[$], got_q[$];

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.SETTLE_CYC(S), .DEBOUNCE_SCANS(D), .REPEAT_SCANS(R)) dut (
    .clk(clk), .rst_n(rst_n), .rows(rows), .cols(cols), .key_valid(key_valid),
    .key_code(key_code), .key_ready(key_ready), .key_held(key_held),
    .overrun(overrun), .ovr_clr(ovr_clr));

  // pressed key at position col*4+row pulls its row low while its column is driven low
  always_comb begin
    rows = 4'hf;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!cols[c] && mask[c*4+r]) rows[r] = 1'b0;
  end

  // every accepted transfer, in order
  always @(posedge clk)
    if (rst_n && key_valid && key_ready) got_q.push_back(int'(key_code));

  function automatic logic [15:0] km(input int code);
    km = '0;
    for (int i = 0; i < 16; i++) if (code_tab[i] == code) km[i] = 1'b1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mask = '0; key_ready = 1'b0; ovr_clr = 1'b0;
    repeat (2) @(negedge clk);
    hist.delete(); exp_q.delete(); got_q.delete();
    m_held = 0; m_valid = 0; m_ovr = 0; m_hcode = 0; m_code = 0; m_rep = 0;
    rst_n = 1'b1;
  endtask

  // drives one full scan with fixed keys/ready and advances the scan-level reference
  task automatic scan(input logic [15:0] m, input bit rdy, input bit clr);
    int res, ec;
    bit stable, evt;
    mask = m; key_ready = rdy; ovr_clr = clr;
    if (rdy && m_valid) begin exp_q.push_back(m_code); m_valid = 0; end
    if (clr) m_ovr = 0;
    @(posedge clk); #1 ovr_clr = 1'b0;
    repeat (S*4-1) @(posedge clk);
    #1;
    res = $countones(m) == 1 ? -2 : -1;
    for (int i = 0; i < 16; i++) if (res == -2 && m[i]) res = code_tab[i];
    hist.push_back(res);
    stable = hist.size() >= D;
    for (int i = 1; i < D; i++) if (stable && hist[hist.size()-1-i] != res) stable = 0;
    evt = 0; ec = 0;
    if (stable && res >= 0 && (!m_held || m_hcode != res)) begin
      evt = 1; ec = res; m_held = 1; m_hcode = res; m_rep = 0;
    end else if (stable && res < 0 && m_held) begin
      m_held = 0; m_rep = 0;
    end else if (m_held && REP) begin
      m_rep++;
      if (m_rep == R) begin evt = 1; ec = m_hcode; m_rep = 0; end
    end
    if (evt && m_valid) m_ovr = 1;
    else if (evt) begin m_valid = 1; m_code = ec; end
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checks++;
    if (cols !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'd0 || key_held !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_values cols=%b valid=%b code=%0d held=%b ovr=%b required 1110/0/0/0/0", cols, key_valid, key_code, key_held, overrun);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      exp = 4'b1111 ^ (4'b0001 << ((n / S) % 4));
      checks++;
      if (cols !== exp) begin failures++; $display("FAIL col_seq edge%0d cols=%b required %b", n, cols, exp); end
    end
  endtask

  task automatic test_press_release();
    logic [15:0] k5;
    bit ok;
    k5 = km(5);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      scan(i < 6 ? k5 : 16'h0, 1'b1, 1'b0);
      checks++;
      if (key_valid !== m_valid || key_held !== m_held || overrun !== m_ovr || (m_valid && key_code !== 4'(m_code))) begin
        failures++;
        $display("FAIL press_model scan%0d valid=%b/%b held=%b/%b ovr=%b/%b code=%0d/%0d", i, key_valid, m_valid, key_held, m_held, overrun, m_ovr, key_code, m_code);
      end
      if (i == 2) begin
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd5) begin failures++; $display("FAIL press_event valid=%b code=%0d required 1/5", key_valid, key_code); end
      end
      if (i == 7 || i == 8) begin
        checks++;
        if (key_held !== (i == 7)) begin failures++; $display("FAIL release_held scan%0d held=%b required %b", i, key_held, i == 7); end
      end
    end
    ok = got_q.size() == 1 && exp_q.size() == 1;
    if (ok) ok = got_q[0] == 5 && exp_q[0] == 5;
    checks++;
    if (!ok) begin failures++; $display("FAIL press_transfers got=%0d events required 1 of code 5", got_q.size()); end
  endtask

  task automatic test_bounce();
    logic [15:0] k8;
    k8 = km(8);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      scan(i % 2 == 0 ? k8 : 16'h0, 1'b1, 1'b0);
      checks++;
      if (key_valid !== 1'b0 || key_held !== 1'b0 || key_held !== m_held) begin
        failures++;
        $display("FAIL bounce scan%0d valid=%b held=%b required 0/0", i, key_valid, key_held);
      end
    end
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL bounce_events got=%0d required 0", got_q.size()); end
  endtask

  task automatic test_ghost();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      scan(km(1) | km(2), 1'b1, 1'b0);
      checks++;
      if (key_valid !== 1'b0 || key_held !== 1'b0) begin failures++; $display("FAIL ghost scan%0d valid=%b held=%b required 0/0", i, key_valid, key_held); end
    end
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL ghost_events got=%0d required 0", got_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [15:0] m;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      m = i < 3 ? km(7) : i < 6 ? 16'h0 : km(9);
      scan(m, i == 10, i == 9);
      checks++;
      if (key_valid !== m_valid || key_held !== m_held || overrun !== m_ovr || (m_valid && key_code !== 4'(m_code))) begin
        failures++;
        $display("FAIL bp_model scan%0d valid=%b/%b held=%b/%b ovr=%b/%b code=%0d/%0d", i, key_valid, m_valid, key_held, m_held, overrun, m_ovr, key_code, m_code);
      end
      if (i == 8) begin
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd7 || overrun !== 1'b1) begin failures++; $display("FAIL bp_drop valid=%b code=%0d ovr=%b required 1/7/1", key_valid, key_code, overrun); end
      end
      if (i == 9) begin
        checks++;
        if (overrun !== 1'b0 || key_code !== 4'd7) begin failures++; $display("FAIL bp_clear ovr=%b code=%0d required 0/7", overrun, key_code); end
      end
    end
    checks++;
    if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] != 7)) begin failures++; $display("FAIL bp_transfer got=%0d events required one code 7", got_q.size()); end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    bit ok;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      scan(i < 11 ? km(0) : 16'h0, 1'b1, 1'b0);
      checks++;
      if (key_valid !== m_valid || key_held !== m_held || (m_valid && key_code !== 4'(m_code))) begin
        failures++;
        $display("FAIL repeat_model scan%0d valid=%b/%b held=%b/%b code=%0d/%0d", i, key_valid, m_valid, key_held, m_held, key_code, m_code);
      end
    end
    ok = got_q.size() == 3;
    foreach (got_q[i]) if (got_q[i] != 0) ok = 0;
    checks++;
    if (!ok) begin failures++; $display("FAIL repeat_events got=%0d required 3 of code 0", got_q.size()); end
  endtask
`endif

  task automatic test_random();
    int left, k;
    logic [15:0] m;
    bit rdy, clr, ok;
    left = 0; m = '0;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      if (left == 0) begin
        k = $urandom_range(0, 9);
        m = k < 2 ? 16'h0 : k < 8 ? 16'(1) << $urandom_range(0, 15) :
            k == 8 ? (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15)) : 16'($urandom);
        left = $urandom_range(1, 6);
      end
      left--;
      rdy = $urandom_range(0, 9) < 7;
      clr = $urandom_range(0, 9) == 0;
      scan(m, rdy, clr);
      checks++;
      if (key_valid !== m_valid || key_held !== m_held || overrun !== m_ovr || (m_valid && key_code !== 4'(m_code))) begin
        failures++;
        $display("FAIL random scan%0d valid=%b/%b held=%b/%b ovr=%b/%b code=%0d/%0d", i, key_valid, m_valid, key_held, m_held, overrun, m_ovr, key_code, m_code);
      end
    end
    ok = got_q.size() == exp_q.size();
    foreach (exp_q[i]) if (ok && got_q[i] != exp_q[i]) ok = 0;
    checks++;
    if (!ok) begin failures++; $display("FAIL random_transfers got=%0d required %0d in order", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_mid_handshake();
    do_reset();
    for (int i = 0; i < 3; i++) scan(km(3), 1'b0, 1'b0);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'd3) begin failures++; $display("FAIL pending_event valid=%b code=%0d required 1/3", key_valid, key_code); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 checks++;
    if (key_valid !== 1'b0 || key_held !== 1'b0 || cols !== 4'b1110) begin
      failures++;
      $display("FAIL reset_discard valid=%b held=%b cols=%b required 0/0/1110", key_valid, key_held, cols);
    end
    do_reset();
    for (int i = 0; i < 2; i++) scan(16'h0, 1'b1, 1'b0);
    checks++;
    if (got_q.size() != 0 || key_valid !== 1'b0) begin failures++; $display("FAIL reset_no_transfer got=%0d valid=%b required 0/0", got_q.size(), key_valid); end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_ghost();
    test_backpressure();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    test_random();
    test_reset_mid_handshake();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
